mii_rx_framer: RTL

MII_RX_FRAMER -- requirements
Module: mii_rx_framer

---
 rtl/mii_rx_framer_pkg.sv | 30 +++
 rtl/mii_rx_framer_crc.sv | 21 ++
 rtl/mii_rx_framer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mii_rx_framer_pkg.sv
// Shared types and constants for the MII receive framer.
// Holds the FSM state encoding, CRC-32 constants, preamble/SFD nibbles and the per-nibble CRC step.
package mii_rx_framer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam logic [3:0] PRE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB = 4'hD;

    // Reflected CRC-32 advanced by one nibble, LSB first.
    function automatic logic [31:0] crc_nibble(input logic [31:0] crc_in,
                                               input logic [3:0]  nib);
        logic [31:0] c;
        c = crc_in ^ {28'd0, nib};
        for (int unsigned i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mii_rx_framer_crc.sv
// Nibble-serial reflected CRC-32 register.
// A synchronous clear loads the init value; en advances the register by one nibble.
module crc32_nibble
    import mii_rx_framer_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic [3:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk) begin
        if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_nibble(crc, data);
        end
    end

endmodule

// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, assembles bytes and streams them as AXI-Stream beats.
// Each byte is held one byte time so the final beat can carry axis_last and the frame verdict.
module mii_rx_framer
    import mii_rx_framer_pkg::*;
#(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       valid,
    input  logic [3:0] data,
    input  logic       err,
    output logic [7:0] axis_data,
    output logic       axis_valid,
    output logic       axis_last,
    output logic       axis_user
);

    localparam logic [10:0] MIN_B = 11'(MIN_LEN);
    localparam logic [10:0] MAX_B = 11'(MAX_LEN);

    state_t      state, state_next;
    logic        phase;
    logic [3:0]  low_nib;
    logic [7:0]  held;
    logic        have_held;
    logic [10:0] byte_cnt;
    logic        err_flag;
    logic [31:0] crc;

    logic sfd_hit;
    logic data_nib;
    logic frame_end;
    logic frame_bad;

    crc32_nibble u_crc (
        .clk  (clk),
        .clr  (rst | sfd_hit),
        .en   (data_nib),
        .data (data),
        .crc  (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sfd_hit    = 1'b0;
        data_nib   = 1'b0;
        frame_end  = 1'b0;
        frame_bad  = err_flag || phase || (byte_cnt < MIN_B) || (byte_cnt > MAX_B) ||
                     (crc != CRC_RESIDUE);
        if (ce) begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        state_next = (data == PRE_NIB) ? PREAMBLE : DROP;
                    end
                end
                PREAMBLE: begin
                    if (!valid) begin
                        state_next = IDLE;
                    end else if (data == SFD_NIB) begin
                        state_next = DATA;
                        sfd_hit    = 1'b1;
                    end else if (data != PRE_NIB) begin
                        state_next = DROP;
                    end
                end
                DATA: begin
                    if (!valid) begin
                        state_next = IDLE;
                        frame_end  = 1'b1;
                    end else begin
                        data_nib = 1'b1;
                    end
                end
                DROP: begin
                    if (!valid) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= 1'b0;
            low_nib    <= '0;
            held       <= '0;
            have_held  <= 1'b0;
            byte_cnt   <= '0;
            err_flag   <= 1'b0;
            axis_data  <= '0;
            axis_valid <= 1'b0;
            axis_last  <= 1'b0;
            axis_user  <= 1'b0;
        end else begin
            axis_valid <= 1'b0;
            axis_last  <= 1'b0;
            axis_user  <= 1'b0;
            if (sfd_hit) begin
                phase     <= 1'b0;
                have_held <= 1'b0;
                byte_cnt  <= '0;
                err_flag  <= 1'b0;
            end
            if (data_nib) begin
                if (err) begin
                    err_flag <= 1'b1;
                end
                if (!phase) begin
                    low_nib <= data;
                    phase   <= 1'b1;
                end else begin
                    phase     <= 1'b0;
                    held      <= {data, low_nib};
                    have_held <= 1'b1;
                    if (byte_cnt != '1) begin
                        byte_cnt <= byte_cnt + 11'd1;
                    end
                    // Completing a byte releases the previous one as a non-final beat.
                    if (have_held) begin
                        axis_valid <= 1'b1;
                        axis_data  <= held;
                    end
                end
            end
            if (frame_end) begin
                have_held <= 1'b0;
                if (have_held) begin
                    axis_valid <= 1'b1;
                    axis_last  <= 1'b1;
                    axis_user  <= frame_bad;
                    axis_data  <= held;
                end
            end
        end
    end

endmodule
